// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, command bytes, frame sizing.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SEND,
      ST_ACK,
      ST_WAIT_REL
   } state_e;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_ECHO    = 8'hEE;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] ACK_BYTE    = 8'hFA;

   localparam int FRAME_LEN = 11;
   localparam int CNT_W     = 20;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-byte request/status bundle between a controller and the PS/2 host transmitter.
interface ps2_host_tx_if;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   modport master (output tx_data, tx_valid, input tx_ready, tx_busy, tx_done, tx_error);
   modport slave  (input tx_data, tx_valid, output tx_ready, tx_busy, tx_done, tx_error);

endinterface

// File: rtl/ps2_line_sync.sv
// Synchroniser for the raw PS2_CLK/PS2_DAT pins with registered falling-edge flags.
module ps2_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic clk_s_o,
   output logic dat_s_o,
   output logic clk_fall_o,
   output logic dat_fall_o
);

   // bit 0 = clk, bit 1 = dat; idle bus level is high
   logic [SYNC_STAGES-1:0][1:0] sync_q;
   logic [1:0]                  prev_q;
   logic [1:0]                  fall_q;
   logic [1:0]                  line_s;

   assign line_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '1;
         prev_q <= '1;
         fall_q <= '0;
      end else begin
         sync_q[0] <= {ps2_dat_i, ps2_clk_i};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= line_s;
         fall_q <= prev_q & ~line_s;
      end
   end

   assign clk_s_o    = line_s[0];
   assign dat_s_o    = line_s[1];
   assign clk_fall_o = fall_q[0];
   assign dat_fall_o = fall_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clock out 8 data +
// odd parity + stop on device clock falls, then collect the device ack bit.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_FREQ_HZ    = 50_000_000,
   parameter int INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
   parameter int TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1000) * 15,
   parameter int SYNC_STAGES    = 2
) (
   input  logic    clk_i,
   input  logic    rst_i,
   ps2_host_tx_if.slave tx,
   input  logic    ps2_clk_i,
   input  logic    ps2_dat_i,
   output logic    ps2_clk_oe_o,
   output logic    ps2_dat_oe_o
);

   localparam logic [CNT_W-1:0] INH_LIM = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [3:0]       LAST_TX = 4'(FRAME_LEN - 2);

   logic clk_s, dat_s, clk_fall, dat_fall;

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .ps2_clk_i (ps2_clk_i),
      .ps2_dat_i (ps2_dat_i),
      .clk_s_o   (clk_s),
      .dat_s_o   (dat_s),
      .clk_fall_o(clk_fall),
      .dat_fall_o(dat_fall)
   );

   logic unused_dat_fall;
   assign unused_dat_fall = dat_fall;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_q, bit_d;
   logic [9:0]       frame_q, frame_d;
   logic             drv_q, drv_d;
   logic             clk_oe, dat_oe, done, err, tmo;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         frame_q <= '0;
         drv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         drv_q   <= drv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      bit_d   = bit_q;
      frame_d = frame_q;
      drv_d   = drv_q;
      clk_oe  = 1'b0;
      dat_oe  = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      // counter keeps running from RTS onwards so it bounds the whole device exchange
      tmo     = (state_q inside {ST_RTS, ST_SEND, ST_ACK, ST_WAIT_REL}) && (cnt_q >= TMO_LIM);

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (tx.tx_valid) begin
               frame_d = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
               state_d = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            clk_oe = 1'b1;
            if (cnt_q == INH_LIM) begin
               cnt_d   = '0;
               state_d = ST_RTS;
            end
         end
         ST_RTS: begin
            dat_oe  = 1'b1;
            bit_d   = '0;
            drv_d   = 1'b1;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            dat_oe = drv_q;
            if (clk_fall) begin
               bit_d   = bit_q + 1'b1;
               drv_d   = ~frame_q[0];
               frame_d = {1'b0, frame_q[9:1]};
               if (bit_q == LAST_TX) state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               if (!dat_s) state_d = ST_WAIT_REL;
               else begin
                  err     = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WAIT_REL: begin
            if (clk_s && dat_s) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (tmo) begin
         clk_oe  = 1'b0;
         dat_oe  = 1'b0;
         done    = 1'b0;
         err     = 1'b1;
         state_d = ST_IDLE;
      end
   end

   assign ps2_clk_oe_o = clk_oe;
   assign ps2_dat_oe_o = dat_oe;
   assign tx.tx_ready  = (state_q == ST_IDLE);
   assign tx.tx_busy   = (state_q != ST_IDLE);
   assign tx.tx_done   = done;
   assign tx.tx_error  = err;

endmodule
